epu_layer_sequencer: RTL and testbench

//  Sequences ConvAcc through a programmed list of layers without host involvement per layer.

---
 rtl/epu_seq_pkg.sv | 58 +++++
 rtl/epu_desc_table.sv | 35 +++
 rtl/epu_layer_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_epu_layer_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epu_seq_pkg.sv
// Shared types and helpers for the EPU layer sequencer.
// Contents:
//    op_e         descriptor op codes (NOP, CONV_1x1, CONV_3x3, MAX_POOL)
//    desc_t       one descriptor table entry (op + 32-bit w8)
//    state_e      sequencer FSM states
//    MODE_*       ConvAcc one-hot mode bit positions and the idle mode word
//    op2mode()    op code -> one-hot ConvAcc mode
package epu_seq_pkg;

   localparam int MODE_W = 4;
   localparam int W8_W   = 32;

   // ConvAcc one-hot mode bit positions
   localparam int MODE_BIT_IDLE  = 0;
   localparam int MODE_BIT_CONV1 = 1;
   localparam int MODE_BIT_CONV3 = 2;
   localparam int MODE_BIT_POOL  = 3;

   localparam logic [MODE_W-1:0] MODE_IDLE = 4'b0001;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_CONV1 = 2'd1,
      OP_CONV3 = 2'd2,
      OP_POOL  = 2'd3
   } op_e;

   typedef struct packed {
      op_e              op;
      logic [W8_W-1:0]  w8;
   } desc_t;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_LOAD  = 4'd1,
      ST_SETUP = 4'd2,
      ST_START = 4'd3,
      ST_WAIT  = 4'd4,
      ST_DRAIN = 4'd5,
      ST_ADV   = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERR   = 4'd8
   } state_e;

   // Map a descriptor op to the one-hot ConvAcc mode; NOP maps to idle
   function automatic logic [MODE_W-1:0] op2mode(input op_e op);
      logic [MODE_W-1:0] m;
      m = '0;
      case (op)
         OP_CONV1: m[MODE_BIT_CONV1] = 1'b1;
         OP_CONV3: m[MODE_BIT_CONV3] = 1'b1;
         OP_POOL:  m[MODE_BIT_POOL]  = 1'b1;
         default:  m[MODE_BIT_IDLE]  = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/epu_desc_table.sv
// Descriptor table: DEPTH entries of {op, w8}, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
// Ports:
//    clk    in   clock
//    we     in   write strobe
//    waddr  in   write index
//    wdata  in   descriptor to store
//    raddr  in   read index
//    rdata  out  descriptor at raddr (combinational)
module epu_desc_table
   import epu_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  desc_t            wdata,
   input  logic [IDX_W-1:0] raddr,
   output desc_t            rdata
);

   desc_t mem_q [DEPTH];

   // Descriptor storage write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/epu_layer_sequencer.sv
// EPU layer sequencer: walks descriptors 0..count-1, driving ConvAcc with the
// mode/w8 of each layer, pulsing start and waiting for finish, with a per-layer
// watchdog and an abort input.
// Ports:
//    clk, rstn                 clock, async active-low reset
//    cfg_we/addr/op/w8         host descriptor write (ignored while busy)
//    run, num_layers           start a run of num_layers layers (clamped to DEPTH)
//    abort                     level; forces ERR from any non-idle state
//    tmo_limit                 watchdog cycles per layer, 0 = disabled
//    acc_mode/w8/start         ConvAcc controls (all registered)
//    acc_finish                ConvAcc completion, only observed in WAIT
//    busy, layer_idx, done, err  status
module epu_layer_sequencer
   import epu_seq_pkg::*;
#(
   parameter  int DEPTH     = 16,
   parameter  int TIMEOUT_W = 24,
   localparam int IDX_W     = $clog2(DEPTH),
   localparam int TMO_W     = (TIMEOUT_W > 0) ? TIMEOUT_W : 1
)(
   input  logic               clk,
   input  logic               rstn,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_addr,
   input  logic [1:0]         cfg_op,
   input  logic [W8_W-1:0]    cfg_w8,
   input  logic               run,
   input  logic [IDX_W:0]     num_layers,
   input  logic               abort,
   input  logic [TMO_W-1:0]   tmo_limit,
   output logic [MODE_W-1:0]  acc_mode,
   output logic [W8_W-1:0]    acc_w8,
   output logic               acc_start,
   input  logic               acc_finish,
   output logic               busy,
   output logic [IDX_W-1:0]   layer_idx,
   output logic               done,
   output logic               err
);

   state_e              state_q,     state_d;
   logic [IDX_W-1:0]    idx_q,       idx_d;
   logic [IDX_W:0]      count_q,     count_d;
   logic [TMO_W-1:0]    wdog_q,      wdog_d;
   logic [MODE_W-1:0]   acc_mode_q,  acc_mode_d;
   logic [W8_W-1:0]     acc_w8_q,    acc_w8_d;
   logic                acc_start_q, acc_start_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                err_q,       err_d;

   desc_t               wr_desc_s;
   desc_t               rd_desc_s;
   logic                cfg_wr_en_s;
   logic                run_accept_s;
   logic                tmo_hit_s;
   logic                idx_last_s;
   logic [IDX_W:0]      num_clamped_s;

   assign cfg_wr_en_s = cfg_we & ~busy_q;
   assign wr_desc_s   = '{op: op_e'(cfg_op), w8: cfg_w8};

   epu_desc_table #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_desc_table (
      .clk   (clk),
      .we    (cfg_wr_en_s),
      .waddr (cfg_addr),
      .wdata (wr_desc_s),
      .raddr (idx_q),
      .rdata (rd_desc_s)
   );

   assign run_accept_s  = (state_q == ST_IDLE) && run;
   assign num_clamped_s = (num_layers > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : num_layers;
   // idx is compared one bit wider than the table index so that count==DEPTH works
   assign idx_last_s    = (({1'b0, idx_q} + (IDX_W+1)'(1)) == count_q);

   // The watchdog expires on the WAIT cycle in which the count would reach tmo_limit
   if (TIMEOUT_W > 0) begin : g_wdog
      assign tmo_hit_s = (tmo_limit != '0) && ((wdog_q + TMO_W'(1)) == tmo_limit);
   end else begin : g_no_wdog
      assign tmo_hit_s = 1'b0;
   end

   // Next-state, layer index, latched count and watchdog counter
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      wdog_d  = wdog_q;
      // abort beats finish and the watchdog, and suppresses any start this cycle
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_ERR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run) begin
                  idx_d   = '0;
                  count_d = num_clamped_s;
                  if (num_clamped_s == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (rd_desc_s.op == OP_NOP) begin
                  state_d = ST_ADV;
               end else begin
                  state_d = ST_SETUP;
               end
            end
            ST_SETUP: state_d = ST_START;
            ST_START: begin
               wdog_d  = '0;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (acc_finish) begin
                  state_d = ST_DRAIN;
               end else if (tmo_hit_s) begin
                  state_d = ST_ERR;
               end else begin
                  wdog_d  = wdog_q + TMO_W'(1);
                  state_d = ST_WAIT;
               end
            end
            ST_DRAIN: state_d = ST_ADV;
            ST_ADV: begin
               // idx stays on the last layer so layer_idx reports it after DONE
               if (idx_last_s) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_LOAD;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output register next values, derived from the upcoming state so that
   // every output lines up with the state it belongs to
   always_comb begin
      acc_start_d = (state_d == ST_START);
      busy_d      = (state_d inside {ST_LOAD, ST_SETUP, ST_START, ST_WAIT, ST_DRAIN, ST_ADV});
      done_d      = (state_d == ST_DONE);

      if (state_d == ST_ERR) begin
         err_d = 1'b1;
      end else if (run_accept_s) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      // mode/w8 are captured on LOAD->SETUP and held through WAIT; w8 is left
      // at the last layer's value, only mode returns to idle
      if (state_d == ST_SETUP) begin
         acc_mode_d = op2mode(rd_desc_s.op);
         acc_w8_d   = rd_desc_s.w8;
      end else if (state_d inside {ST_START, ST_WAIT}) begin
         acc_mode_d = acc_mode_q;
         acc_w8_d   = acc_w8_q;
      end else begin
         acc_mode_d = MODE_IDLE;
         acc_w8_d   = acc_w8_q;
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         count_q     <= '0;
         wdog_q      <= '0;
         acc_mode_q  <= MODE_IDLE;
         acc_w8_q    <= '0;
         acc_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         count_q     <= count_d;
         wdog_q      <= wdog_d;
         acc_mode_q  <= acc_mode_d;
         acc_w8_q    <= acc_w8_d;
         acc_start_q <= acc_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign acc_mode  = acc_mode_q;
   assign acc_w8    = acc_w8_q;
   assign acc_start = acc_start_q;
   assign busy      = busy_q;
   assign layer_idx = idx_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_epu_layer_sequencer.sv
// Directed testbench for epu_layer_sequencer. Inputs change 1 time unit after
// the rising edge and outputs are checked there, i.e. well away from the edge.
module tb_epu_layer_sequencer;

   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic              clk = 1'b0;
   logic              rstn;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_addr;
   logic [1:0]        cfg_op;
   logic [31:0]       cfg_w8;
   logic              run;
   logic [IDX_W:0]    num_layers;
   logic              abort;
   logic [23:0]       tmo_limit;
   logic [3:0]        acc_mode;
   logic [31:0]       acc_w8;
   logic              acc_start;
   logic              acc_finish;
   logic              busy;
   logic [IDX_W-1:0]  layer_idx;
   logic              done;
   logic              err;

   int n_checks  = 0;
   int n_errors  = 0;
   int start_cnt = 0;
   int done_cnt  = 0;

   // expected layer_idx / acc_start per cycle after layer 0's DRAIN when descriptor 1 is NOP
   int exp_idx3 [6] = '{0, 1, 1, 2, 2, 2};
   int exp_st3  [6] = '{0, 0, 0, 0, 0, 1};

   epu_layer_sequencer #(.DEPTH(DEPTH), .TIMEOUT_W(24)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_op     (cfg_op),
      .cfg_w8     (cfg_w8),
      .run        (run),
      .num_layers (num_layers),
      .abort      (abort),
      .tmo_limit  (tmo_limit),
      .acc_mode   (acc_mode),
      .acc_w8     (acc_w8),
      .acc_start  (acc_start),
      .acc_finish (acc_finish),
      .busy       (busy),
      .layer_idx  (layer_idx),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge
   always @(negedge clk) begin
      if (acc_start === 1'b1) start_cnt++;
      if (done === 1'b1) done_cnt++;
   end

   // Hard time limit so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_desc(input int a, input logic [1:0] op, input logic [31:0] w);
      cfg_we   = 1'b1;
      cfg_addr = a[IDX_W-1:0];
      cfg_op   = op;
      cfg_w8   = w;
      tick();
      cfg_we   = 1'b0;
   endtask

   // Tick until acc_start is seen or the budget runs out; lat = ticks taken
   task automatic wait_start(input int budget, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while ((acc_start !== 1'b1) && (lat < budget));
   endtask

   // Issue a run pulse; afterwards the DUT is in its first post-run cycle
   task automatic do_run(input int n);
      run        = 1'b1;
      num_layers = n[IDX_W:0];
      tick();
      run        = 1'b0;
   endtask

   // From START: one WAIT cycle, finish high, land in DRAIN
   task automatic finish_layer();
      tick();
      acc_finish = 1'b1;
      tick();
      acc_finish = 1'b0;
   endtask

   function automatic logic [3:0] mode_of(input int op);
      case (op)
         1:       return 4'b0010;
         2:       return 4'b0100;
         3:       return 4'b1000;
         default: return 4'b0001;
      endcase
   endfunction

   initial begin
      int lat;
      int s0;
      int d0;
      logic [31:0] w;

      rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_op = 2'd0; cfg_w8 = 32'd0;
      run = 1'b0; num_layers = '0; abort = 1'b0; tmo_limit = 24'd0; acc_finish = 1'b0;

      // Reset values
      repeat (3) tick();
      chk("rst_mode", acc_mode, 4'b0001);
      chk("rst_w8", acc_w8, 32'd0);
      chk("rst_start", acc_start, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_idx", layer_idx, 4'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // 1/2: three layers CONV_3x3, MAX_POOL, CONV_1x1 with latency checks
      wr_desc(0, 2'd2, 32'h0000_00A5);
      wr_desc(1, 2'd3, 32'h0000_0011);
      wr_desc(2, 2'd1, 32'h0000_003C);
      s0 = start_cnt; d0 = done_cnt;
      do_run(3);
      chk("t1_busy_load", busy, 1'b1);
      chk("t1_mode_load", acc_mode, 4'b0001);
      wait_start(10, lat);
      // run cycle, LOAD, SETUP, START: start in the 4th cycle = 3 edges after run
      chk("t2_run_to_start", lat + 1, 3);
      chk("t1_l0_mode", acc_mode, 4'b0100);
      chk("t1_l0_w8", acc_w8, 32'h0000_00A5);
      chk("t1_l0_idx", layer_idx, 4'd0);
      tick();
      chk("t1_start_1cyc", acc_start, 1'b0);
      // host write to the executing entry while busy: must not take effect
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_op = 2'd1; cfg_w8 = 32'hFFFF_FFFF;
      tick();
      cfg_we = 1'b0;
      acc_finish = 1'b1;
      tick();
      acc_finish = 1'b0;
      chk("t1_drain_mode", acc_mode, 4'b0001);
      chk("t2_w8_stable_drain", acc_w8, 32'h0000_00A5);
      wait_start(10, lat);
      // finish cycle then DRAIN, ADV, LOAD, SETUP, START
      chk("t2_finish_to_start", lat + 1, 5);
      chk("t1_l1_mode", acc_mode, 4'b1000);
      chk("t1_l1_w8", acc_w8, 32'h0000_0011);
      chk("t1_l1_idx", layer_idx, 4'd1);
      finish_layer();
      wait_start(10, lat);
      chk("t1_l2_mode", acc_mode, 4'b0010);
      chk("t1_l2_w8", acc_w8, 32'h0000_003C);
      chk("t1_l2_idx", layer_idx, 4'd2);
      finish_layer();
      tick();
      chk("t1_adv_no_done", done, 1'b0);
      chk("t1_adv_busy", busy, 1'b1);
      tick();
      chk("t1_done", done, 1'b1);
      chk("t1_done_busy", busy, 1'b0);
      tick();
      chk("t1_done_pulse", done, 1'b0);
      chk("t1_start_count", start_cnt - s0, 3);
      chk("t1_done_count", done_cnt - d0, 1);

      // 3: descriptor 1 = NOP, only two starts
      wr_desc(1, 2'd0, 32'h0000_0077);
      s0 = start_cnt;
      do_run(3);
      wait_start(10, lat);
      chk("t3_l0_w8_kept", acc_w8, 32'h0000_00A5);
      chk("t3_l0_mode", acc_mode, 4'b0100);
      finish_layer();
      chk("t3_drain_idx", layer_idx, 4'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t3_idx_%0d", i), layer_idx, exp_idx3[i]);
         chk($sformatf("t3_start_%0d", i), acc_start, exp_st3[i]);
      end
      chk("t3_l2_mode", acc_mode, 4'b0010);
      finish_layer();
      tick();
      tick();
      chk("t3_done", done, 1'b1);
      tick();
      chk("t3_start_count", start_cnt - s0, 2);

      // 4: watchdog, finish never rises
      tmo_limit = 24'd10;
      d0 = done_cnt;
      do_run(1);
      wait_start(10, lat);
      repeat (10) tick();
      chk("t4_err_before", err, 1'b0);
      chk("t4_busy_before", busy, 1'b1);
      tick();
      chk("t4_err", err, 1'b1);
      chk("t4_err_busy", busy, 1'b0);
      chk("t4_err_mode", acc_mode, 4'b0001);
      chk("t4_err_done", done, 1'b0);
      tick();
      chk("t4_err_sticky", err, 1'b1);
      do_run(1);
      chk("t4_run_clears_err", err, 1'b0);
      wait_start(10, lat);
      finish_layer();
      tick();
      tick();
      chk("t4_done2", done, 1'b1);
      tick();
      chk("t4_done_count", done_cnt - d0, 1);

      // 5: abort together with finish in WAIT; run while busy ignored
      tmo_limit = 24'd0;
      s0 = start_cnt;
      do_run(3);
      wait_start(10, lat);
      tick();
      run = 1'b1; num_layers = 5'd1;
      tick();
      run = 1'b0;
      chk("t5_run_busy_ignored", busy, 1'b1);
      chk("t5_still_mode", acc_mode, 4'b0100);
      abort = 1'b1; acc_finish = 1'b1;
      tick();
      abort = 1'b0; acc_finish = 1'b0;
      chk("t5_abort_err", err, 1'b1);
      chk("t5_abort_busy", busy, 1'b0);
      chk("t5_abort_idx", layer_idx, 4'd0);
      chk("t5_abort_mode", acc_mode, 4'b0001);
      repeat (6) tick();
      chk("t5_no_more_start", start_cnt - s0, 1);
      // abort in SETUP must not yield a start
      s0 = start_cnt;
      do_run(1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_setup_abort_start", acc_start, 1'b0);
      chk("t5_setup_abort_err", err, 1'b1);
      tick();
      chk("t5_setup_abort_count", start_cnt - s0, 0);

      // 6: zero-layer run, full table with clamped count, async reset mid-WAIT
      do_run(0);
      chk("t6_zero_done", done, 1'b1);
      chk("t6_zero_busy", busy, 1'b0);
      chk("t6_zero_err_clr", err, 1'b0);
      tick();
      chk("t6_zero_done_pulse", done, 1'b0);

      for (int i = 0; i < DEPTH; i++) begin
         w = 32'hC0DE_0000 + 32'(i);
         wr_desc(i, 2'((i % 3) + 1), w);
      end
      s0 = start_cnt;
      do_run(31);
      for (int i = 0; i < DEPTH; i++) begin
         wait_start(10, lat);
         w = 32'hC0DE_0000 + 32'(i);
         chk($sformatf("t6_idx_%0d", i), layer_idx, i);
         chk($sformatf("t6_mode_%0d", i), acc_mode, mode_of((i % 3) + 1));
         chk($sformatf("t6_w8_%0d", i), acc_w8, w);
         finish_layer();
      end
      tick();
      tick();
      chk("t6_full_done", done, 1'b1);
      chk("t6_full_last_idx", layer_idx, 4'd15);
      tick();
      chk("t6_full_start_count", start_cnt - s0, 16);

      do_run(1);
      wait_start(10, lat);
      tick();
      #2;
      rstn = 1'b0;
      #1;
      chk("t6_arst_mode", acc_mode, 4'b0001);
      chk("t6_arst_w8", acc_w8, 32'd0);
      chk("t6_arst_start", acc_start, 1'b0);
      chk("t6_arst_busy", busy, 1'b0);
      chk("t6_arst_done", done, 1'b0);
      chk("t6_arst_err", err, 1'b0);
      chk("t6_arst_idx", layer_idx, 4'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();
      chk("t6_post_rst_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
